mult_alu_sequencer: RTL

- Multi-cycle sequencer that performs unsigned 32x32 -> 64-bit multiplication (MULTU) by borrowing the shared 32-bit EX-stage ALU one add per cycle.
- Uses a radix-2 shift-add algorithm and arbitrates ALU access with the pipeline through a req/gnt handshake.
- Sits beside the EX stage. The pipeline stalls on busy and reads hi_out/lo_out after done.

---
 rtl/mult_alu_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/mult_alu_sequencer.sv
// rtl/mult_alu_sequencer.sv - unsigned WIDTHxWIDTH multiplier that borrows the shared EX-stage ALU one add per cycle
module mult_alu_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             alu_gnt,
    input  logic [WIDTH-1:0] alu_out,
    output logic             alu_req,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_operation,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0]       ALU_ADD  = 3'b010;
    localparam logic [2:0]       ALU_NONE = 3'b000;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry;

    // State and datapath registers; reset aborts any multiply in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, shift-add step and ALU request/operand outputs
    always_comb begin
        state_d       = state_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        mcand_d       = mcand_q;
        cnt_d         = cnt_q;
        carry         = 1'b0;
        alu_req       = 1'b0;
        alu_a         = '0;
        alu_b         = '0;
        alu_operation = ALU_NONE;
        busy          = 1'b0;
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = op_a;
                    hi_d    = '0;
                    lo_d    = op_b;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end

            S_ITER: begin
                busy          = 1'b1;
                alu_req       = 1'b1;
                alu_a         = hi_q;
                alu_b         = lo_q[0] ? mcand_q : '0;
                alu_operation = ALU_ADD;
                // A cycle without grant leaves every register untouched
                if (alu_gnt) begin
                    // The wrapped sum is smaller than hi exactly when the add overflowed
                    carry = (alu_out < hi_q);
                    hi_d  = {carry, alu_out[WIDTH-1:1]};
                    lo_d  = {alu_out[0], lo_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule
